// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, instruction-memory request and IF/ID pipeline register.
// Latency: one cycle from an imem_ready strobe to the word appearing in IF/ID.
// Backpressure: stall holds PC and IF/ID; imem_ready low inserts bubbles; HLT freezes fetch until a branch.
// Optional feature: define FETCH_PERF_CNT_EN to enable the saturating fetch/flush performance counters.
module fetch_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        branch,
   input  logic [15:0] pc_next,
   input  logic        stall,
   output logic        imem_req,
   output logic [15:0] imem_addr,
   input  logic [15:0] imem_rdata,
   input  logic        imem_ready,
   output logic [15:0] pc_output,
   output logic [15:0] if_id_instr,
   output logic [15:0] if_id_pc_inc,
   output logic        if_id_valid,
   output logic        halted,
   output logic [15:0] fetch_cnt,
   output logic [15:0] flush_cnt
);

   localparam logic [3:0] OP_HLT = 4'hF;

   logic [15:0] pc_inc;
   logic        fetch_done;
   logic        is_hlt;

   // Sequential PC increment wraps naturally at 16 bits (0xFFFE -> 0x0000).
   assign pc_inc     = pc_output + 16'd2;
   assign imem_req   = !halted && !stall;
   assign imem_addr  = pc_output;
   assign fetch_done = imem_req && imem_ready;
   assign is_hlt     = (imem_rdata[15:12] == OP_HLT);

   // PC / IF/ID / halt state: branch beats stall beats halt-freeze beats fetch beats wait.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_output    <= 16'h0000;
         if_id_instr  <= 16'h0000;
         if_id_pc_inc <= 16'h0000;
         if_id_valid  <= 1'b0;
         halted       <= 1'b0;
      end else if (branch) begin
         // Redirect squashes whatever is in IF/ID and also releases a halt.
         pc_output   <= pc_next;
         if_id_instr <= 16'h0000;
         if_id_valid <= 1'b0;
         halted      <= 1'b0;
      end else if (stall) begin
         // Hazard hold: everything keeps its value.
      end else if (halted) begin
         // Frozen: the HLT stays visible for one cycle, then only bubbles.
         if_id_valid <= 1'b0;
      end else if (fetch_done) begin
         if_id_instr  <= imem_rdata;
         if_id_pc_inc <= pc_inc;
         if_id_valid  <= 1'b1;
         if (is_hlt) begin
            halted <= 1'b1;
         end else begin
            pc_output <= pc_inc;
         end
      end else begin
         // Memory not ready: hold PC and data, emit a bubble.
         if_id_valid <= 1'b0;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_q;
   logic [15:0] flush_q;

   // Saturating counters: completed fetches (never on a redirect cycle) and redirects.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_q <= 16'h0000;
         flush_q <= 16'h0000;
      end else begin
         if (fetch_done && !branch && (fetch_q != 16'hFFFF)) begin
            fetch_q <= fetch_q + 16'd1;
         end
         if (branch && (flush_q != 16'hFFFF)) begin
            flush_q <= flush_q + 16'd1;
         end
      end
   end

   assign fetch_cnt = fetch_q;
   assign flush_cnt = flush_q;
`else
   assign fetch_cnt = 16'h0000;
   assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic
// against a cycle-level reference model of the fetch rules.
module tb_fetch_stage;

   logic        clk;
   logic        rst_n;
   logic        branch;
   logic [15:0] pc_next;
   logic        stall;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_ready;
   logic [15:0] pc_output;
   logic [15:0] if_id_instr;
   logic [15:0] if_id_pc_inc;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_cnt;
   logic [15:0] flush_cnt;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // reference model state
   logic [15:0] m_pc, m_instr, m_pcinc;
   logic        m_valid, m_halted;
   int          m_fetches, m_flushes;

   fetch_stage dut (
      .clk(clk), .rst_n(rst_n), .branch(branch), .pc_next(pc_next), .stall(stall),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .imem_ready(imem_ready), .pc_output(pc_output), .if_id_instr(if_id_instr),
      .if_id_pc_inc(if_id_pc_inc), .if_id_valid(if_id_valid), .halted(halted),
      .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counter values visible at the ports depend on whether the counters are built.
   function automatic logic [15:0] exp_cnt(input int n);
`ifdef FETCH_PERF_CNT_EN
      return (n > 65535) ? 16'hFFFF : n[15:0];
`else
      return 16'h0000;
`endif
   endfunction

   task automatic model_reset();
      m_pc = 16'h0000; m_instr = 16'h0000; m_pcinc = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_fetches = 0; m_flushes = 0;
   endtask

   // One clock edge of the fetch rules, evaluated on the inputs present at the edge.
   task automatic model_edge();
      if (branch) begin
         m_pc = pc_next; m_valid = 1'b0; m_instr = 16'h0000; m_halted = 1'b0;
         m_flushes++;
      end else if (stall) begin
         // hold
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else if (imem_ready) begin
         m_instr = imem_rdata;
         m_pcinc = 16'((32'(m_pc) + 2) % 65536);
         m_valid = 1'b1;
         m_fetches++;
         if (imem_rdata[15:12] == 4'hF) m_halted = 1'b1;
         else m_pc = m_pcinc;
      end else begin
         m_valid = 1'b0;
      end
   endtask

   task automatic drive(input logic br, input logic stl, input logic rdy,
                        input logic [15:0] nxt, input logic [15:0] rd);
      branch = br; stall = stl; imem_ready = rdy; pc_next = nxt; imem_rdata = rd;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   // Asynchronous reset pulse away from the clock edge, released on a falling edge.
   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      rst_n = 1'b1;
      #12 rst_n = 1'b0;
      model_reset();
      #1;
      total_cnt++; if (pc_output !== 16'h0000) $display("FAIL reset_pc got %h want 0000", pc_output); else pass_cnt++;
      total_cnt++; if (if_id_instr !== 16'h0000) $display("FAIL reset_instr got %h want 0000", if_id_instr); else pass_cnt++;
      total_cnt++; if (if_id_pc_inc !== 16'h0000) $display("FAIL reset_pc_inc got %h want 0000", if_id_pc_inc); else pass_cnt++;
      total_cnt++; if (if_id_valid !== 1'b0 || halted !== 1'b0) $display("FAIL reset_flags got v=%b h=%b want 0 0", if_id_valid, halted); else pass_cnt++;
      total_cnt++; if (fetch_cnt !== 16'h0000 || flush_cnt !== 16'h0000) $display("FAIL reset_cnt got %h %h want 0000 0000", fetch_cnt, flush_cnt); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) $display("FAIL reset_release_req got req=%b addr=%h want 1 0000", imem_req, imem_addr); else pass_cnt++;
   endtask

   task automatic test_sequential();
      do_reset();
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1123);
      #1;
      total_cnt++; if (imem_addr !== 16'h0000) $display("FAIL seq_addr0 got %h want 0000", imem_addr); else pass_cnt++;
      tick();
      total_cnt++; if (imem_addr !== 16'h0002 || if_id_pc_inc !== 16'h0002 || if_id_valid !== 1'b1) $display("FAIL seq_first got addr=%h inc=%h v=%b want 0002 0002 1", imem_addr, if_id_pc_inc, if_id_valid); else pass_cnt++;
      total_cnt++; if (if_id_instr !== 16'h1123) $display("FAIL seq_instr0 got %h want 1123", if_id_instr); else pass_cnt++;
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h2456);
      tick();
      total_cnt++; if (imem_addr !== 16'h0004 || if_id_pc_inc !== 16'h0004 || if_id_instr !== 16'h2456) $display("FAIL seq_second got addr=%h inc=%h instr=%h want 0004 0004 2456", imem_addr, if_id_pc_inc, if_id_instr); else pass_cnt++;
      total_cnt++; if (fetch_cnt !== exp_cnt(2)) $display("FAIL seq_fetch_cnt got %h want %h", fetch_cnt, exp_cnt(2)); else pass_cnt++;
   endtask

   task automatic test_stall();
      drive(1'b1, 1'b0, 1'b0, 16'h000E, 16'hFFFF);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h3ABC);
      tick();
      total_cnt++; if (pc_output !== 16'h0010 || if_id_instr !== 16'h3ABC) $display("FAIL stall_setup got pc=%h instr=%h want 0010 3abc", pc_output, if_id_instr); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 16'h0000, 16'($urandom));
         #1;
         total_cnt++; if (imem_req !== 1'b0) $display("FAIL stall_req cycle %0d got %b want 0", i, imem_req); else pass_cnt++;
         tick();
         total_cnt++; if (pc_output !== 16'h0010 || if_id_instr !== 16'h3ABC || if_id_pc_inc !== 16'h0010 || if_id_valid !== 1'b1) $display("FAIL stall_hold cycle %0d got pc=%h instr=%h inc=%h v=%b want 0010 3abc 0010 1", i, pc_output, if_id_instr, if_id_pc_inc, if_id_valid); else pass_cnt++;
      end
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h4001);
      #1;
      total_cnt++; if (imem_req !== 1'b1 || imem_addr !== 16'h0010) $display("FAIL stall_resume got req=%b addr=%h want 1 0010", imem_req, imem_addr); else pass_cnt++;
      tick();
   endtask

   task automatic test_branch_priority();
      drive(1'b1, 1'b1, 1'b0, 16'h0040, 16'h7777);
      tick();
      total_cnt++; if (pc_output !== 16'h0040 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0000) $display("FAIL branch_stall got pc=%h v=%b instr=%h want 0040 0 0000", pc_output, if_id_valid, if_id_instr); else pass_cnt++;
      total_cnt++; if (flush_cnt !== exp_cnt(m_flushes)) $display("FAIL branch_flush_cnt got %h want %h", flush_cnt, exp_cnt(m_flushes)); else pass_cnt++;
   endtask

   task automatic test_halt();
      drive(1'b1, 1'b0, 1'b0, 16'h0020, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'hF000);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234);
      #1;
      total_cnt++; if (halted !== 1'b1 || pc_output !== 16'h0020 || imem_req !== 1'b0) $display("FAIL halt_enter got h=%b pc=%h req=%b want 1 0020 0", halted, pc_output, imem_req); else pass_cnt++;
      total_cnt++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'hF000) $display("FAIL halt_latched got v=%b instr=%h want 1 f000", if_id_valid, if_id_instr); else pass_cnt++;
      tick();
      total_cnt++; if (halted !== 1'b1 || if_id_valid !== 1'b0 || pc_output !== 16'h0020 || if_id_instr !== 16'hF000) $display("FAIL halt_frozen got h=%b v=%b pc=%h instr=%h want 1 0 0020 f000", halted, if_id_valid, pc_output, if_id_instr); else pass_cnt++;
      drive(1'b1, 1'b0, 1'b1, 16'h0030, 16'h1234);
      tick();
      total_cnt++; if (halted !== 1'b0 || pc_output !== 16'h0030) $display("FAIL halt_release got h=%b pc=%h want 0 0030", halted, pc_output); else pass_cnt++;
   endtask

   task automatic test_wrap();
      drive(1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h0000);
      tick();
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h1234);
      tick();
      total_cnt++; if (pc_output !== 16'h0000 || if_id_pc_inc !== 16'h0000 || if_id_valid !== 1'b1) $display("FAIL wrap got pc=%h inc=%h v=%b want 0000 0000 1", pc_output, if_id_pc_inc, if_id_valid); else pass_cnt++;
   endtask

   task automatic test_wait_reset();
      drive(1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000);
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'hF0F0);
         tick();
         total_cnt++; if (if_id_valid !== 1'b0 || pc_output !== 16'h0100 || halted !== 1'b0) $display("FAIL wait_bubble %0d got v=%b pc=%h h=%b want 0 0100 0", i, if_id_valid, pc_output, halted); else pass_cnt++;
      end
      drive(1'b0, 1'b0, 1'b1, 16'h0000, 16'h5555);
      tick();
      total_cnt++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'h5555 || pc_output !== 16'h0102) $display("FAIL wait_latch got v=%b instr=%h pc=%h want 1 5555 0102", if_id_valid, if_id_instr, pc_output); else pass_cnt++;
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h6666);
      tick();
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      total_cnt++; if (pc_output !== 16'h0000 || fetch_cnt !== 16'h0000 || flush_cnt !== 16'h0000 || if_id_valid !== 1'b0) $display("FAIL wait_reset got pc=%h fc=%h flc=%h v=%b want 0000 0000 0000 0", pc_output, fetch_cnt, flush_cnt, if_id_valid); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_random();
      logic [15:0] rd;
      for (int i = 0; i < 400; i++) begin
         rd = 16'($urandom);
         if ($urandom_range(0, 9) != 0 && rd[15:12] == 4'hF) rd[15:12] = 4'h1;
         drive(($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
               ($urandom_range(0, 9) < 6), 16'($urandom) & 16'hFFFE, rd);
         #1;
         total_cnt++; if (imem_req !== (!m_halted && !stall) || imem_addr !== m_pc) $display("FAIL rand_req cycle %0d got req=%b addr=%h want %b %h", i, imem_req, imem_addr, (!m_halted && !stall), m_pc); else pass_cnt++;
         tick();
         total_cnt++; if (pc_output !== m_pc || if_id_instr !== m_instr || if_id_pc_inc !== m_pcinc) $display("FAIL rand_regs cycle %0d got pc=%h instr=%h inc=%h want %h %h %h", i, pc_output, if_id_instr, if_id_pc_inc, m_pc, m_instr, m_pcinc); else pass_cnt++;
         total_cnt++; if (if_id_valid !== m_valid || halted !== m_halted) $display("FAIL rand_flags cycle %0d got v=%b h=%b want %b %b", i, if_id_valid, halted, m_valid, m_halted); else pass_cnt++;
         total_cnt++; if (fetch_cnt !== exp_cnt(m_fetches) || flush_cnt !== exp_cnt(m_flushes)) $display("FAIL rand_cnt cycle %0d got %h %h want %h %h", i, fetch_cnt, flush_cnt, exp_cnt(m_fetches), exp_cnt(m_flushes)); else pass_cnt++;
      end
   endtask

   initial begin
      rst_n = 1'b1;
      model_reset();
      test_reset();
      test_sequential();
      test_stall();
      test_branch_priority();
      test_halt();
      test_wrap();
      test_wait_reset();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
